alu_src_sequencer: RTL and testbench
====================================

// Module: alu_src_sequencer
// PURPOSE
//   Multicycle control FSM that drives the ALU operand-select side of the datapath: it decides,
//   every cycle, which operand the ALU second-input mux takes (BOut / constant 4 / sign-ext imm /
//   shifted imm), the ALU first input, the ALU operation and the datapath write enables.
//   Sits between the instruction register (opcode/funct), the ALU zero flag and the datapath muxes.
// PARAMETERS
//   COUNT_W   16   width of retired-instruction counter instr_count
// PORTS
//   clk          in   1        system clock, all state updates on rising edge
//   reset        in   1        synchronous, active-high reset
//   opcode       in   6        IR[31:26]; must be stable from DECODE until return to FETCH
//   funct        in   6        IR[5:0]; same stability rule
//   zero         in   1        ALU zero flag, valid in BRANCH state
//   mem_ready    in   1        instruction memory read data valid this cycle
//   ALU1control  out  1        0 = PC, 1 = AOut
//   ALU2control  out  2        00 BOut, 01 constant 4, 10 sign-ext imm, 11 shifted imm
//   ALUop        out  3        000 add, 001 sub, 010 and, 011 or, 100 slt
//   PCWrite      out  1        PC load enable
//   PCSource     out  1        0 = ALU result, 1 = ALUOut register
//   IRWrite      out  1        instruction register load enable
//   ALUOutWrite  out  1        ALUOut register load enable
//   RegWrite     out  1        register file write enable
//   RegDst       out  1        1 = rd (R-type), 0 = rt (I-type)
//   illegal      out  1        sticky unsupported-instruction flag
//   state_dbg    out  3        current state encoding
//   instr_count  out  COUNT_W  retired instructions, wraps to 0 after all-ones
// BEHAVIOUR
//   - Moore FSM; all outputs decode from registered state (+ zero in BRANCH, mem_ready in FETCH).
//   - reset=1 at edge: state<=RESET(0), instr_count<=0, RegDst<=0; overrides everything incl. mid-instr.
//   - Unlisted outputs are 0 in each state. States / encoding:
//     RESET(0):   all outputs 0 -> FETCH.
//     FETCH(1):   ALU1=0, ALU2=01, ALUop=add, PCSource=0; IRWrite=PCWrite=mem_ready.
//                 mem_ready=0 -> stay FETCH (no PC/IR write); mem_ready=1 -> DECODE.
//     DECODE(2):  ALU1=0, ALU2=11, add, ALUOutWrite=1 (branch target). Decode opcode:
//                 0x00 & funct in {0x20,0x22,0x24,0x25,0x2A} -> EXEC_R, RegDst<=1;
//                 0x08 (addi) -> EXEC_I, RegDst<=0; 0x04 beq / 0x05 bne -> BRANCH;
//                 anything else -> ILLEGAL.
//     EXEC_R(3):  ALU1=1, ALU2=00, ALUop from funct (20 add,22 sub,24 and,25 or,2A slt),
//                 ALUOutWrite=1 -> WB.
//     EXEC_I(4):  ALU1=1, ALU2=10, add, ALUOutWrite=1 -> WB.
//     BRANCH(5):  ALU1=1, ALU2=00, sub, PCSource=1; PCWrite = zero (beq) / ~zero (bne);
//                 instr_count++ -> FETCH.
//     WB(6):      RegWrite=1, RegDst=latched value; instr_count++ -> FETCH.
//     ILLEGAL(7): illegal=1, all enables 0; stays until reset.
//   - Latency: R/I-type 4 cycles (FETCH..WB), branch 3 cycles, plus 1 per mem_ready=0 cycle.
//   - instr_count increments exactly once per completed instruction, taken or not; wraps mod 2^COUNT_W.
//   - RegDst is a register: holds across cycles; only written in DECODE and by reset.
// TESTING
//   1 reset 3 cycles, release, mem_ready=1, opcode=00 funct=20 -> states 0,1,2,3,6,1; in 3 ALU2=00,
//     ALUop=000; in 6 RegWrite=1 RegDst=1; instr_count=1.
//   2 addi (opcode=08) -> EXEC_I shows ALU2=10 ALU1=1; WB RegDst=0; FETCH shows ALU2=01, DECODE ALU2=11.
//   3 beq zero=1 -> BRANCH PCWrite=1 PCSource=1 ALUop=001; bne zero=1 -> PCWrite=0; both count +1.
//   4 mem_ready low 5 cycles in FETCH -> state stays 1, PCWrite=IRWrite=0; on high both pulse 1 cycle.
//   5 opcode=0x23 or opcode=00 funct=0x08 -> ILLEGAL, illegal=1 held 20 cycles; reset clears to RESET.
//   6 COUNT_W=4: 16 addi instructions -> instr_count 15 then 0; reset asserted in EXEC_R -> RESET, count 0.

Source files
------------

// File: rtl/alu_src_sequencer.sv
// Multicycle control FSM for the ALU operand-select side of the datapath.
// It selects the ALU operands, the ALU operation and the datapath write enables, and counts retired instructions.
module alu_src_sequencer #(
   parameter int COUNT_W = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [5:0]         opcode,
   input  logic [5:0]         funct,
   input  logic               zero,
   input  logic               mem_ready,
   output logic               ALU1control,
   output logic [1:0]         ALU2control,
   output logic [2:0]         ALUop,
   output logic               PCWrite,
   output logic               PCSource,
   output logic               IRWrite,
   output logic               ALUOutWrite,
   output logic               RegWrite,
   output logic               RegDst,
   output logic               illegal,
   output logic [2:0]         state_dbg,
   output logic [COUNT_W-1:0] instr_count
);

   typedef enum logic [2:0] {
      S_RESET   = 3'd0,
      S_FETCH   = 3'd1,
      S_DECODE  = 3'd2,
      S_EXEC_R  = 3'd3,
      S_EXEC_I  = 3'd4,
      S_BRANCH  = 3'd5,
      S_WB      = 3'd6,
      S_ILLEGAL = 3'd7
   } state_t;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_SLT = 3'b100;

   localparam logic [COUNT_W-1:0] COUNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

   state_t             state;
   state_t             next_state;
   logic               reg_dst;
   logic [COUNT_W-1:0] count;
   logic               funct_ok;
   logic [2:0]         funct_op;

   always_comb begin
      funct_ok = 1'b1;
      funct_op = OP_ADD;
      case (funct)
         6'h20:   funct_op = OP_ADD;
         6'h22:   funct_op = OP_SUB;
         6'h24:   funct_op = OP_AND;
         6'h25:   funct_op = OP_OR;
         6'h2A:   funct_op = OP_SLT;
         default: funct_ok = 1'b0;
      endcase
   end

   // RegDst is latched once per instruction in DECODE; branches and illegal decodes leave it alone.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_RESET;
         reg_dst <= 1'b0;
         count   <= '0;
      end else begin
         state <= next_state;
         if (state == S_DECODE && next_state == S_EXEC_R) reg_dst <= 1'b1;
         if (state == S_DECODE && next_state == S_EXEC_I) reg_dst <= 1'b0;
         if (state == S_BRANCH || state == S_WB) count <= count + COUNT_ONE;
      end
   end

   // mem_ready acts as the fetch handshake: PC and IR load only in the cycle it is high.
   always_comb begin
      next_state  = state;
      ALU1control = 1'b0;
      ALU2control = 2'b00;
      ALUop       = OP_ADD;
      PCWrite     = 1'b0;
      PCSource    = 1'b0;
      IRWrite     = 1'b0;
      ALUOutWrite = 1'b0;
      RegWrite    = 1'b0;
      illegal     = 1'b0;
      case (state)
         S_RESET: next_state = S_FETCH;
         S_FETCH: begin
            ALU2control = 2'b01;
            PCWrite     = mem_ready;
            IRWrite     = mem_ready;
            if (mem_ready) next_state = S_DECODE;
         end
         S_DECODE: begin
            ALU2control = 2'b11;
            ALUOutWrite = 1'b1;
            if (opcode == 6'h00 && funct_ok)      next_state = S_EXEC_R;
            else if (opcode == 6'h08)             next_state = S_EXEC_I;
            else if (opcode == 6'h04 || opcode == 6'h05) next_state = S_BRANCH;
            else                                  next_state = S_ILLEGAL;
         end
         S_EXEC_R: begin
            ALU1control = 1'b1;
            ALU2control = 2'b00;
            ALUop       = funct_op;
            ALUOutWrite = 1'b1;
            next_state  = S_WB;
         end
         S_EXEC_I: begin
            ALU1control = 1'b1;
            ALU2control = 2'b10;
            ALUOutWrite = 1'b1;
            next_state  = S_WB;
         end
         S_BRANCH: begin
            ALU1control = 1'b1;
            ALU2control = 2'b00;
            ALUop       = OP_SUB;
            PCSource    = 1'b1;
            PCWrite     = (opcode == 6'h05) ? ~zero : zero;
            next_state  = S_FETCH;
         end
         S_WB: begin
            RegWrite   = 1'b1;
            next_state = S_FETCH;
         end
         S_ILLEGAL: illegal = 1'b1;
         default:   next_state = S_RESET;
      endcase
   end

   assign RegDst      = reg_dst;
   assign state_dbg   = state;
   assign instr_count = count;

endmodule

// File: tb/tb_alu_src_sequencer.sv
// Scoreboard bench for alu_src_sequencer: per-cycle expected output vectors are queued by the
// drivers and popped by a negedge monitor.
module tb_alu_src_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       zero;
   logic       mem_ready;
   logic       ALU1control;
   logic [1:0] ALU2control;
   logic [2:0] ALUop;
   logic       PCWrite;
   logic       PCSource;
   logic       IRWrite;
   logic       ALUOutWrite;
   logic       RegWrite;
   logic       RegDst;
   logic       illegal;
   logic [2:0] state_dbg;
   logic [3:0] instr_count;

   alu_src_sequencer #(.COUNT_W(4)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
      .mem_ready(mem_ready), .ALU1control(ALU1control), .ALU2control(ALU2control),
      .ALUop(ALUop), .PCWrite(PCWrite), .PCSource(PCSource), .IRWrite(IRWrite),
      .ALUOutWrite(ALUOutWrite), .RegWrite(RegWrite), .RegDst(RegDst),
      .illegal(illegal), .state_dbg(state_dbg), .instr_count(instr_count)
   );

   // clock / reset
   always #5 clk = ~clk;

   // scoreboard
   logic [19:0] exp_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          n_popped = 0;
   logic [3:0]  exp_cnt;
   logic        exp_rd;

   // Vector layout: state, ALU1, ALU2, ALUop, PCWrite, PCSource, IRWrite, ALUOutWrite, RegWrite, RegDst, illegal, count
   function automatic logic [19:0] mk(input logic [2:0] st, input logic a1, input logic [1:0] a2,
                                      input logic [2:0] op, input logic pcw, input logic pcs,
                                      input logic irw, input logic aow, input logic rw,
                                      input logic rd, input logic ill, input logic [3:0] cnt);
      mk = {st, a1, a2, op, pcw, pcs, irw, aow, rw, rd, ill, cnt};
   endfunction

   always @(negedge clk) begin
      logic [19:0] act;
      logic [19:0] e;
      if (exp_q.size() > 0) begin
         e   = exp_q.pop_front();
         act = {state_dbg, ALU1control, ALU2control, ALUop, PCWrite, PCSource, IRWrite,
                ALUOutWrite, RegWrite, RegDst, illegal, instr_count};
         n_checks++;
         if (act !== e) begin
            n_fail++;
            $display("FAIL cycle_vec idx=%0d got=%h expected=%h (state got %0d expected %0d)",
                     n_popped, act, e, act[19:17], e[19:17]);
         end
         n_popped++;
      end
   end

   // driver tasks
   task automatic cyc(input logic [19:0] e);
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic fetch(input int waits);
      mem_ready = 1'b0;
      for (int i = 0; i < waits; i++)
         cyc(mk(3'd1, 1'b0, 2'b01, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp_rd, 1'b0, exp_cnt));
      mem_ready = 1'b1;
      cyc(mk(3'd1, 1'b0, 2'b01, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, exp_rd, 1'b0, exp_cnt));
      mem_ready = 1'b0;
      cyc(mk(3'd2, 1'b0, 2'b11, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, exp_rd, 1'b0, exp_cnt));
   endtask

   task automatic do_r(input logic [5:0] fn, input logic [2:0] op, input int waits);
      opcode = 6'h00;
      funct  = fn;
      fetch(waits);
      exp_rd = 1'b1;
      cyc(mk(3'd3, 1'b1, 2'b00, op, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, exp_rd, 1'b0, exp_cnt));
      cyc(mk(3'd6, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, exp_rd, 1'b0, exp_cnt));
      exp_cnt = exp_cnt + 4'd1;
   endtask

   task automatic do_i();
      opcode = 6'h08;
      funct  = 6'h3F;
      fetch(0);
      exp_rd = 1'b0;
      cyc(mk(3'd4, 1'b1, 2'b10, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, exp_rd, 1'b0, exp_cnt));
      cyc(mk(3'd6, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, exp_rd, 1'b0, exp_cnt));
      exp_cnt = exp_cnt + 4'd1;
   endtask

   task automatic do_br(input logic [5:0] opc, input logic z, input logic taken);
      opcode = opc;
      funct  = 6'h20;
      zero   = z;
      fetch(0);
      cyc(mk(3'd5, 1'b1, 2'b00, 3'b001, taken, 1'b1, 1'b0, 1'b0, 1'b0, exp_rd, 1'b0, exp_cnt));
      exp_cnt = exp_cnt + 4'd1;
      zero    = 1'b0;
   endtask

   task automatic do_illegal(input logic [5:0] opc, input logic [5:0] fn);
      opcode = opc;
      funct  = fn;
      fetch(0);
      for (int i = 0; i < 20; i++)
         cyc(mk(3'd7, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp_rd, 1'b1, exp_cnt));
   endtask

   // Assert reset while the current-state vector is e_now; afterwards the FSM sits in RESET.
   task automatic do_reset(input logic [19:0] e_now, input int hold);
      reset = 1'b1;
      cyc(e_now);
      exp_cnt = 4'd0;
      exp_rd  = 1'b0;
      for (int i = 1; i < hold; i++) cyc(mk(3'd0, 0, 2'b00, 3'b000, 0, 0, 0, 0, 0, 0, 0, 4'd0));
      reset = 1'b0;
      cyc(mk(3'd0, 0, 2'b00, 3'b000, 0, 0, 0, 0, 0, 0, 0, 4'd0));
   endtask

   initial begin
      int budget;
      reset     = 1'b1;
      opcode    = 6'h00;
      funct     = 6'h20;
      zero      = 1'b0;
      mem_ready = 1'b0;
      exp_cnt   = 4'd0;
      exp_rd    = 1'b0;
      @(posedge clk);
      #1;
      // 3 reset cycles (first edge already taken), then release
      cyc(mk(3'd0, 0, 2'b00, 3'b000, 0, 0, 0, 0, 0, 0, 0, 4'd0));
      cyc(mk(3'd0, 0, 2'b00, 3'b000, 0, 0, 0, 0, 0, 0, 0, 4'd0));
      reset = 1'b0;
      cyc(mk(3'd0, 0, 2'b00, 3'b000, 0, 0, 0, 0, 0, 0, 0, 4'd0));

      do_r(6'h20, 3'b000, 0);
      do_r(6'h22, 3'b001, 0);
      do_r(6'h24, 3'b010, 0);
      do_r(6'h25, 3'b011, 0);
      do_r(6'h2A, 3'b100, 0);
      do_i();
      do_br(6'h04, 1'b1, 1'b1);
      do_br(6'h04, 1'b0, 1'b0);
      do_br(6'h05, 1'b1, 1'b0);
      do_br(6'h05, 1'b0, 1'b1);
      do_r(6'h22, 3'b001, 5);

      do_illegal(6'h23, 6'h20);
      do_reset(mk(3'd7, 0, 2'b00, 3'b000, 0, 0, 0, 0, 0, exp_rd, 1'b1, exp_cnt), 1);
      do_r(6'h20, 3'b000, 0);
      do_illegal(6'h00, 6'h08);
      do_reset(mk(3'd7, 0, 2'b00, 3'b000, 0, 0, 0, 0, 0, exp_rd, 1'b1, exp_cnt), 2);

      // counter wrap: 16 instructions from 0 ends back at 0
      for (int i = 0; i < 16; i++) do_i();
      opcode = 6'h00;
      funct  = 6'h25;
      fetch(0);
      exp_rd = 1'b1;
      do_reset(mk(3'd3, 1'b1, 2'b00, 3'b011, 0, 0, 0, 1'b1, 0, exp_rd, 0, exp_cnt), 1);
      mem_ready = 1'b1;
      cyc(mk(3'd1, 1'b0, 2'b01, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0));

      budget = 0;
      while (exp_q.size() > 0 && budget < 10) begin
         @(posedge clk);
         budget++;
      end
      if (exp_q.size() > 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain queue_left=%0d expected=0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
